// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed 7-segment scan driver.
//   - Active-low glyph constants SEG_0..SEG_F and SEG_BLANK, bit order {g,f,e,d,c,b,a}.
//   - Scan FSM state enum (BLANK / SHOW).
// No ports (package).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundles the digit-load inputs and the display outputs.
//   load     1             strobe; capture digits/dp_in
//   digits   4*NUM_DIGITS  digit codes, digit 0 in bits [3:0]
//   dp_in    NUM_DIGITS    decimal point per digit, 1 = lit
//   an_out   NUM_DIGITS    anode enables, active-low
//   seg_out  7             segments {g,f,e,d,c,b,a}, active-low
//   dp_out   1             decimal point, active-low
// Modports: master = digit source / display consumer, slave = the driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [6:0]              seg_out;
  logic                    dp_out;

  modport master (
    output load, digits, dp_in,
    input  an_out, seg_out, dp_out
  );

  modport slave (
    input  load, digits, dp_in,
    output an_out, seg_out, dp_out
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational 4-bit code to active-low 7-segment glyph (full hex).
//   code   in   4   digit code 0..15
//   glyph  out  7   {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  // Glyph lookup; 10..15 render as A,b,C,d,E,F.
  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = SEG_A;
      4'hB:    glyph = SEG_B;
      4'hC:    glyph = SEG_C;
      4'hD:    glyph = SEG_D;
      4'hE:    glyph = SEG_E;
      4'hF:    glyph = SEG_F;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment display driver.
//   Latches NUM_DIGITS digit codes on load, scans them onto one shared active-low
//   segment bus with per-digit active-low anodes, and blanks all anodes for
//   BLANK_CYCLES at the start of every slot to suppress ghosting.
// Ports:
//   CLK    in  1   system clock, posedge
//   RESET  in  1   synchronous, active-high; wins over load
//   bus    seg7_scan_driver_if.slave (load/digits/dp_in in, an_out/seg_out/dp_out out)
// Parameters: NUM_DIGITS, REFRESH_DIV (clocks per slot, >= BLANK_CYCLES+2),
//   BLANK_CYCLES (>= 1), PRESC_WIDTH (must hold REFRESH_DIV-1).
// Configuration macro: SEG7_LEADING_ZERO_BLANK_EN -- when defined, a digit above
//   index 0 shows no segments if it and every higher digit are zero (anode and
//   decimal point still driven normally).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int PRESC_WIDTH  = 16
) (
  input logic                CLK,
  input logic                RESET,
  seg7_scan_driver_if.slave  bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  logic [PRESC_WIDTH-1:0]      presc_r;
  logic [IDX_W-1:0]            idx_r;
  logic [BLANK_W-1:0]          blank_cnt_r;
  state_e                      state_r;
  state_e                      state_nxt_s;
  logic [NUM_DIGITS-1:0][3:0]  shadow_r;
  logic [NUM_DIGITS-1:0]       dp_shadow_r;
  logic                        wrap_s;
  logic                        blank_done_s;
  logic [6:0]                  glyph_s;
  logic [NUM_DIGITS-1:0]       lz_blank_s;
  logic [NUM_DIGITS-1:0]       an_nxt_s;
  logic [6:0]                  seg_nxt_s;
  logic                        dp_nxt_s;
  logic [NUM_DIGITS-1:0]       an_r;
  logic [6:0]                  seg_r;
  logic                        dp_r;

  assign wrap_s       = (presc_r == PRESC_WIDTH'(REFRESH_DIV - 1));
  assign blank_done_s = (blank_cnt_r == BLANK_W'(BLANK_CYCLES - 1));

  // Scan FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= BLANK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan FSM next state: a prescaler wrap always restarts the slot in BLANK.
  always_comb begin
    state_nxt_s = state_r;
    if (wrap_s) begin
      state_nxt_s = BLANK;
    end else begin
      case (state_r)
        BLANK:   state_nxt_s = blank_done_s ? SHOW : BLANK;
        SHOW:    state_nxt_s = SHOW;
        default: state_nxt_s = BLANK;
      endcase
    end
  end

  // Prescaler, digit index, blank counter and shadow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_r     <= {PRESC_WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      blank_cnt_r <= {BLANK_W{1'b0}};
      shadow_r    <= {(4*NUM_DIGITS){1'b0}};
      dp_shadow_r <= {NUM_DIGITS{1'b0}};
    end else begin
      if (wrap_s) begin
        presc_r     <= {PRESC_WIDTH{1'b0}};
        blank_cnt_r <= {BLANK_W{1'b0}};
        if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        presc_r <= presc_r + PRESC_WIDTH'(1);
        if (state_r == BLANK) begin
          blank_cnt_r <= blank_cnt_r + BLANK_W'(1);
        end
      end
      // Shadow copy decouples the display from the producer: a digit is
      // re-read from shadow every cycle, so an update lands whole, never torn.
      if (bus.load) begin
        shadow_r    <= bus.digits;
        dp_shadow_r <= bus.dp_in;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .code  (shadow_r[idx_r]),
    .glyph (glyph_s)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Mark digits above index 0 that are zero along with every higher digit.
  always_comb begin
    logic zero_above_s;
    lz_blank_s   = {NUM_DIGITS{1'b0}};
    zero_above_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above_s  = zero_above_s & (shadow_r[i] == 4'h0);
      lz_blank_s[i] = zero_above_s;
    end
  end
`else
  assign lz_blank_s = {NUM_DIGITS{1'b0}};
`endif

  // Scan FSM outputs: next values for the registered display pins.
  always_comb begin
    an_nxt_s  = {NUM_DIGITS{1'b1}};
    seg_nxt_s = SEG_BLANK;
    dp_nxt_s  = 1'b1;
    if (state_r == SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_nxt_s[i] = (idx_r != IDX_W'(i));
      end
      if (lz_blank_s[idx_r]) begin
        seg_nxt_s = SEG_BLANK;
      end else begin
        seg_nxt_s = glyph_s;
      end
      dp_nxt_s = ~dp_shadow_r[idx_r];
    end else begin
      an_nxt_s  = {NUM_DIGITS{1'b1}};
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
    end
  end

  // Output registers keep the pins glitch-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      an_r  <= {NUM_DIGITS{1'b1}};
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign bus.an_out  = an_r;
  assign bus.seg_out = seg_r;
  assign bus.dp_out  = dp_r;

endmodule
